if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Front-end pipeline boundary directly downstream of instruction_fetch.
- Aligns the synchronous-BRAM instruction output with its PC, and holds the IF/ID pipeline register.
- Decodes J/JAL in ID and drives jump_sel/jump_address back to the fetch PC mux.
- Detects load-use hazards and drives PC_write. Squashes wrong-path instructions on a taken branch or a jump.
- A skid register preserves the in-flight BRAM word across stalls.

Parameters:
- AW, 10, instruction address width (PC, jump_address)
- DW, 32, instruction width

Ports:
- clock  in  1  single clock; all state rises on posedge
- reset  in  1  asynchronous, active-high
- instruc  in  DW  BRAM douta; word for the PC sampled at the previous edge
- PC_current  in  AW  current PC register value, sampled by BRAM each edge
- branch_taken  in  1  taken branch resolved in EX; same signal as fetch PC_sel
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rt  in  5  destination rt of that load
- PC_write  out  1  PC register enable
- jump_sel  out  1  select jump_address at fetch PC mux
- jump_address  out  AW  instr_id[AW-1:0]
- instr_id  out  DW  IF/ID instruction
- pc_plus1_id  out  AW  IF/ID PC+1, mod 2^AW
- valid_id  out  1  IF/ID holds a real instruction
- bubble  out  1  ID/EX must load a NOP/zero controls this cycle

Behaviour:
- Reset (async): f_valid=0, pc_f=0, skid_valid=0, IF/ID {instr=0, pc=0, valid=0}.
- Resulting outputs during reset: PC_write=1, jump_sel=0, bubble=1, valid_id=0.
- Fetch alignment:
  - pc_f <= PC_current every edge, so pc_f always tags instruc.
  - f_valid <= 1 on every edge except redirect; on redirect f_valid <= 0.
  - f_valid holds on a stall edge.
- hazard = valid_id & id_ex_mem_read & (id_ex_rt != 0) & (id_ex_rt == instr_id[25:21] | id_ex_rt == instr_id[20:16]). J/JAL are compared conservatively.
- stall = hazard & ~branch_taken.
- is_jump = valid_id & opcode in {J, JAL}.
- jump_sel = is_jump & ~stall & ~branch_taken.
- redirect = branch_taken | jump_sel.
- PC_write = ~stall.
- bubble = ~valid_id | hazard | branch_taken.
- A jump is not bubbled; it proceeds to EX (JAL needs its link value).
- Stall edge:
  - IF/ID holds.
  - On the first stall cycle (skid_valid=0): skid <= {instruc, pc_f, f_valid}; skid_valid <= 1.
  - skid is not rewritten while skid_valid=1.
- Normal edge:
  - If skid_valid, IF/ID <= skid and skid_valid <= 0.
  - Otherwise IF/ID <= {instruc, pc_f, f_valid}.
- Redirect edge (priority over the normal edge): IF/ID.valid <= 0, skid_valid <= 0, f_valid <= 0.
- Priority: reset > branch_taken > stall > jump > normal.
- branch_taken during a stall releases the stall and flushes.
- pc_plus1_id = IF/ID.pc + 1, computed combinationally. 0x3FF wraps to 0x000.
- Latency: an instruction fetched at PC P is visible in instr_id 2 edges after PC_current==P, absent stalls.
- Mid-operation reset clears everything immediately. No partial skid state survives.

Decomposition:
- Shared package (if_id_pkg), one section per constant kind:
  - opcode constants: OP_J=6'b000010, OP_JAL=6'b000011
  - NOP_INSTR=32'h0
  - field slices: opcode [31:26], rs [25:21], rt [20:16]
- One combinational sub-module, hazard_detect: inputs instr_id, valid_id, id_ex_mem_read, id_ex_rt, branch_taken; outputs hazard and stall.
- Skid and IF/ID registers stay in the top.

Test Plan:
- Reset, release, BRAM model holds word k at address k. Then: instr_id sequence 0,1,2… beginning 2 edges after release; pc_plus1_id = pc+1; valid_id=1 from the first loaded word.
- Load-use: ID/EX lw rt=5, instr_id rs=5. Then: PC_write=0 and bubble=1 for 1 cycle; instr_id held; the next instr_id equals the preserved skid word (P-1, not P); no instruction lost or duplicated.
- 3-cycle back-to-back stall, then release. Then: skid captured only on cycle 1; post-release sequence contiguous.
- instr_id = J 0x120 with no hazard. Then: jump_sel=1, jump_address=0x120, PC_write=1; the next two fetched words have valid_id=0; the first valid instruction after the jump has pc=0x120.
- branch_taken during an active load-use stall. Then: PC_write=1, bubble=1, skid_valid cleared, next two valid_id=0.
- IF/ID.pc=0x3FF. Then: pc_plus1_id=0x000. Separately, id_ex_rt=0 with a matching rs gives hazard=0.
- Reset asserted mid-stall. Then: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/if_id_pkg.sv
// if_id_pkg: shared constants, field positions and small helpers for the
// IF/ID pipeline boundary.
package if_id_pkg;

    // ---------------------------------------------------------------
    // Opcode constants
    // ---------------------------------------------------------------
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    // ---------------------------------------------------------------
    // Fill values
    // ---------------------------------------------------------------
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // ---------------------------------------------------------------
    // Instruction field slices
    // ---------------------------------------------------------------
    localparam int unsigned OPCODE_HI = 31;
    localparam int unsigned OPCODE_LO = 26;
    localparam int unsigned RS_HI     = 25;
    localparam int unsigned RS_LO     = 21;
    localparam int unsigned RT_HI     = 20;
    localparam int unsigned RT_LO     = 16;

    // ---------------------------------------------------------------
    // What the IF/ID boundary does on the coming clock edge
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {
        EDGE_NORMAL   = 2'd0,
        EDGE_STALL    = 2'd1,
        EDGE_REDIRECT = 2'd2
    } edge_kind_e;

    // True for the unconditional jump opcodes decoded in ID.
    function automatic logic is_jump_op(input logic [5:0] opcode);
        return (opcode == OP_J) || (opcode == OP_JAL);
    endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// hazard_detect: load-use hazard detection for the instruction held in ID.
// Purely combinational; a taken branch overrides the stall because the
// instruction in ID is about to be squashed anyway.
module hazard_detect
    import if_id_pkg::*;
#(
    parameter int unsigned DW = 32
)
(
    input  logic [DW-1:0] instr_id,
    input  logic          valid_id,
    input  logic          id_ex_mem_read,
    input  logic [4:0]    id_ex_rt,
    input  logic          branch_taken,
    output logic          hazard,
    output logic          stall
);

    logic [4:0] rs_field;
    logic [4:0] rt_field;
    logic       unused_fields;

    assign rs_field = instr_id[RS_HI:RS_LO];
    assign rt_field = instr_id[RT_HI:RT_LO];

    // Opcode and immediate bits take no part in the register comparison.
    assign unused_fields = ^{instr_id[DW-1:RS_HI+1], instr_id[RT_LO-1:0]};

    // Compare the load destination against both source fields; J/JAL are
    // compared too since their target bits are not decoded here.
    always_comb begin
        hazard = 1'b0;
        if (valid_id && id_ex_mem_read && (id_ex_rt != 5'd0)) begin
            hazard = (id_ex_rt == rs_field) || (id_ex_rt == rt_field);
        end
        stall = hazard & ~branch_taken;
    end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID boundary behind a synchronous-BRAM instruction fetch.
// Tags the BRAM word with its PC, holds the IF/ID register, keeps a skid
// copy of the in-flight word across load-use stalls, resolves J/JAL in ID
// and squashes wrong-path fetches on any redirect.
module if_id_stage
    import if_id_pkg::*;
#(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
)
(
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] instruc,
    input  logic [AW-1:0] PC_current,
    input  logic          branch_taken,
    input  logic          id_ex_mem_read,
    input  logic [4:0]    id_ex_rt,
    output logic          PC_write,
    output logic          jump_sel,
    output logic [AW-1:0] jump_address,
    output logic [DW-1:0] instr_id,
    output logic [AW-1:0] pc_plus1_id,
    output logic          valid_id,
    output logic          bubble
);

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    // Fetch alignment: PC sampled alongside the BRAM address.
    logic          f_valid_q,    f_valid_d;
    logic [AW-1:0] pc_f_q,       pc_f_d;

    // Skid copy of the BRAM word that was in flight when a stall began.
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_instr_q, skid_instr_d;
    logic [AW-1:0] skid_pc_q,    skid_pc_d;
    logic          skid_fv_q,    skid_fv_d;

    // IF/ID pipeline register.
    logic [DW-1:0] ifid_instr_q, ifid_instr_d;
    logic [AW-1:0] ifid_pc_q,    ifid_pc_d;
    logic          ifid_valid_q, ifid_valid_d;

    logic          hazard;
    logic          stall;
    logic          is_jump;
    edge_kind_e    edge_kind;

    hazard_detect #(
        .DW (DW)
    ) u_hazard_detect (
        .instr_id       (ifid_instr_q),
        .valid_id       (ifid_valid_q),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .branch_taken   (branch_taken),
        .hazard         (hazard),
        .stall          (stall)
    );

    // ID-stage decode and control outputs back to fetch and ID/EX.
    always_comb begin
        is_jump      = ifid_valid_q && is_jump_op(ifid_instr_q[OPCODE_HI:OPCODE_LO]);
        jump_sel     = is_jump & ~stall & ~branch_taken;
        jump_address = ifid_instr_q[AW-1:0];
        PC_write     = ~stall;
        bubble       = ~ifid_valid_q | hazard | branch_taken;
        instr_id     = ifid_instr_q;
        valid_id     = ifid_valid_q;
        pc_plus1_id  = ifid_pc_q + PC_ONE;
    end

    // Classify the coming edge: redirect beats stall beats normal advance.
    always_comb begin
        edge_kind = EDGE_NORMAL;
        if (branch_taken || jump_sel) begin
            edge_kind = EDGE_REDIRECT;
        end else if (stall) begin
            edge_kind = EDGE_STALL;
        end
    end

    // Next-state for fetch tag, skid and IF/ID registers.
    always_comb begin
        pc_f_d       = PC_current;
        f_valid_d    = f_valid_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_fv_d    = skid_fv_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;

        case (edge_kind)
            EDGE_REDIRECT: begin
                // The word in flight and anything parked in the skid are
                // wrong-path; the word in ID is either squashed (branch) or
                // leaves for EX unbubbled (jump).
                f_valid_d    = 1'b0;
                skid_valid_d = 1'b0;
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR[DW-1:0];
            end
            EDGE_STALL: begin
                // The PC register holds, so the BRAM will re-read the next
                // address; the word currently on douta would be lost unless
                // captured now. Only the first stall cycle sees that word.
                if (!skid_valid_q) begin
                    skid_instr_d = instruc;
                    skid_pc_d    = pc_f_q;
                    skid_fv_d    = f_valid_q;
                    skid_valid_d = 1'b1;
                end
            end
            default: begin
                f_valid_d = 1'b1;
                if (skid_valid_q) begin
                    ifid_instr_d = skid_instr_q;
                    ifid_pc_d    = skid_pc_q;
                    ifid_valid_d = skid_fv_q;
                    skid_valid_d = 1'b0;
                end else begin
                    ifid_instr_d = instruc;
                    ifid_pc_d    = pc_f_q;
                    ifid_valid_d = f_valid_q;
                end
            end
        endcase
    end

    // State registers; reset clears every stage including the skid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f_valid_q    <= 1'b0;
            pc_f_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_fv_q    <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            f_valid_q    <= f_valid_d;
            pc_f_q       <= pc_f_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_fv_q    <= skid_fv_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: bench for if_id_stage with a PC register and synchronous
// BRAM around it. Directed table plus hand sequences, then random traffic
// checked against a program-order model of what should reach ID.
module tb_if_id_stage;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [5:0]  OPC_J   = 6'b000010;
    localparam logic [5:0]  OPC_JAL = 6'b000011;
    localparam logic [5:0]  OPC_LW  = 6'b100011;
    localparam logic [AW-1:0] PC_ONE = AW'(1);

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] instruc;
    logic [AW-1:0] PC_current;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          id_ex_mem_read;
    logic [4:0]    id_ex_rt;
    logic          PC_write;
    logic          jump_sel;
    logic [AW-1:0] jump_address;
    logic [DW-1:0] instr_id;
    logic [AW-1:0] pc_plus1_id;
    logic          valid_id;
    logic          bubble;

    logic [31:0] mem [DEPTH];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clock = ~clock;

    if_id_stage #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .instruc        (instruc),
        .PC_current     (PC_current),
        .branch_taken   (branch_taken),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .PC_write       (PC_write),
        .jump_sel       (jump_sel),
        .jump_address   (jump_address),
        .instr_id       (instr_id),
        .pc_plus1_id    (pc_plus1_id),
        .valid_id       (valid_id),
        .bubble         (bubble)
    );

    // Fetch-side PC register: branch beats jump beats sequential.
    always @(posedge clock or posedge reset) begin
        if (reset) PC_current <= '0;
        else if (PC_write) PC_current <= branch_taken ? branch_target :
                                         (jump_sel ? jump_address : PC_current + PC_ONE);
    end

    // Synchronous BRAM read port.
    always @(posedge clock) instruc <= mem[PC_current];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] lo);
        return {opc, rs, rt, lo};
    endfunction

    // Non-jump word unique to its address: rs = addr[4:0], rt = addr[9:5].
    function automatic logic [31:0] plain_word(input int unsigned k);
        logic [9:0] a;
        a = 10'(k);
        return {OPC_LW, a[4:0], a[9:5], 6'd0, a};
    endfunction

    task automatic fill_plain();
        for (int unsigned k = 0; k < DEPTH; k++) mem[k] = plain_word(k);
    endtask

    task automatic fill_random();
        logic [31:0] r;
        logic [5:0]  opc;
        int unsigned pick;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            r    = $urandom;
            pick = $urandom_range(0, 15);
            if (pick == 0)      opc = OPC_J;
            else if (pick == 1) opc = OPC_JAL;
            else                opc = OPC_LW ^ 6'(pick);
            mem[k] = {opc, r[25:0]};
        end
    endtask

    task automatic clear_inputs();
        branch_taken   = 1'b0;
        branch_target  = '0;
        id_ex_mem_read = 1'b0;
        id_ex_rt       = 5'd0;
    endtask

    task automatic do_reset(input bit chk);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        if (chk) begin
            check("rst_pc_write", 32'(PC_write), 32'd1);
            check("rst_jump_sel", 32'(jump_sel), 32'd0);
            check("rst_bubble",   32'(bubble),   32'd1);
            check("rst_valid",    32'(valid_id), 32'd0);
            check("rst_instr",    instr_id,      32'd0);
            check("rst_pc1",      32'(pc_plus1_id), 32'd1);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    // After release, word n sits in ID 2+n edges later (no stalls).
    task automatic run_to(input int unsigned n);
        repeat (2 + n) @(posedge clock);
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] word;
        logic        mem_read;
        logic [4:0]  rt;
        logic        br;
        logic        exp_pc_write;
        logic        exp_bubble;
        logic        exp_jump_sel;
    } vec_t;

    function automatic vec_t mkv(input string nm, input logic [31:0] w, input logic mr,
                                 input logic [4:0] rt, input logic br,
                                 input logic pw, input logic bb, input logic js);
        vec_t v;
        v.name = nm; v.word = w; v.mem_read = mr; v.rt = rt; v.br = br;
        v.exp_pc_write = pw; v.exp_bubble = bb; v.exp_jump_sel = js;
        return v;
    endfunction

    // Program-order model of the ID stage contents.
    logic          m_valid;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_next;
    int unsigned   m_dead;

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_next = '0; m_dead = 1;
    endtask

    task automatic model_edge(input logic br, input logic st, input logic js,
                              input logic [AW-1:0] btgt, input logic [AW-1:0] jtgt);
        if (br) begin
            m_valid = 1'b0; m_dead = 1; m_next = btgt;
        end else if (st) begin
            // ID holds its instruction
        end else if (js) begin
            m_valid = 1'b0; m_dead = 1; m_next = jtgt;
        end else if (m_dead > 0) begin
            m_dead--; m_valid = 1'b0;
        end else begin
            m_valid = 1'b1; m_pc = m_next; m_next = m_next + PC_ONE;
        end
    endtask

    vec_t        tbl [10];
    logic [31:0] w;
    logic        hz, st, js;

    initial begin
        reset = 1'b1;
        clear_inputs();

        // ---- reset values and fetch latency ----
        fill_plain();
        do_reset(1'b1);
        step();
        check("lat_e1_valid", 32'(valid_id), 32'd0);
        step();
        check("lat_e2_valid", 32'(valid_id), 32'd1);
        check("lat_e2_instr", instr_id, mem[0]);
        check("lat_e2_pc1",   32'(pc_plus1_id), 32'd1);
        step();
        check("lat_e3_instr", instr_id, mem[1]);
        check("lat_e3_pc1",   32'(pc_plus1_id), 32'd2);

        // ---- combinational control table ----
        tbl[0] = mkv("no_load",    mk(OPC_LW, 5, 7, 16'h0),     0, 5, 0, 1, 0, 0);
        tbl[1] = mkv("rs_match",   mk(OPC_LW, 5, 7, 16'h0),     1, 5, 0, 0, 1, 0);
        tbl[2] = mkv("rt_match",   mk(OPC_LW, 5, 7, 16'h0),     1, 7, 0, 0, 1, 0);
        tbl[3] = mkv("no_match",   mk(OPC_LW, 5, 7, 16'h0),     1, 9, 0, 1, 0, 0);
        tbl[4] = mkv("rt_zero",    mk(OPC_LW, 0, 3, 16'h0),     1, 0, 0, 1, 0, 0);
        tbl[5] = mkv("br_in_stl",  mk(OPC_LW, 5, 5, 16'h0),     1, 5, 1, 1, 1, 0);
        tbl[6] = mkv("j_clean",    mk(OPC_J,  0, 0, 16'h0120),  0, 0, 0, 1, 0, 1);
        tbl[7] = mkv("jal_clean",  mk(OPC_JAL, 0, 0, 16'h03AB), 0, 0, 0, 1, 0, 1);
        tbl[8] = mkv("j_hazard",   mk(OPC_J,  4, 0, 16'h0120),  1, 4, 0, 0, 1, 0);
        tbl[9] = mkv("j_branch",   mk(OPC_J,  0, 0, 16'h0120),  0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            fill_plain();
            mem[0] = tbl[i].word;
            do_reset(1'b0);
            run_to(0);
            check({tbl[i].name, "_loaded"}, instr_id, tbl[i].word);
            id_ex_mem_read = tbl[i].mem_read;
            id_ex_rt       = tbl[i].rt;
            branch_taken   = tbl[i].br;
            branch_target  = 10'h200;
            #1;
            check({tbl[i].name, "_pc_write"}, 32'(PC_write), 32'(tbl[i].exp_pc_write));
            check({tbl[i].name, "_bubble"},   32'(bubble),   32'(tbl[i].exp_bubble));
            check({tbl[i].name, "_jump_sel"}, 32'(jump_sel), 32'(tbl[i].exp_jump_sel));
            if (tbl[i].exp_jump_sel) begin
                w = tbl[i].word;
                check({tbl[i].name, "_jaddr"}, 32'(jump_address), 32'(w[9:0]));
            end
            clear_inputs();
        end

        // ---- 3-cycle load-use stall, skid replay, contiguous stream ----
        fill_plain();
        do_reset(1'b0);
        run_to(5);
        for (int c = 0; c < 3; c++) begin
            id_ex_mem_read = 1'b1;
            id_ex_rt       = 5'd5;
            #1;
            check("stl_pc_write", 32'(PC_write), 32'd0);
            check("stl_bubble",   32'(bubble),   32'd1);
            check("stl_hold",     instr_id,      mem[5]);
            step();
        end
        clear_inputs();
        #1;
        check("stl_release", 32'(PC_write), 32'd1);
        for (int unsigned k = 6; k < 10; k++) begin
            step();
            check("stl_after", instr_id, mem[k]);
            check("stl_after_valid", 32'(valid_id), 32'd1);
        end

        // ---- jump: two squashed slots then target ----
        fill_plain();
        mem[3] = mk(OPC_J, 0, 0, 16'h0120);
        do_reset(1'b0);
        run_to(3);
        check("jmp_sel",      32'(jump_sel),     32'd1);
        check("jmp_addr",     32'(jump_address), 32'h120);
        check("jmp_pc_write", 32'(PC_write),     32'd1);
        check("jmp_bubble",   32'(bubble),       32'd0);
        step();
        check("jmp_slot1", 32'(valid_id), 32'd0);
        step();
        check("jmp_slot2", 32'(valid_id), 32'd0);
        step();
        check("jmp_tgt_valid", 32'(valid_id),    32'd1);
        check("jmp_tgt_instr", instr_id,         mem[12'h120]);
        check("jmp_tgt_pc1",   32'(pc_plus1_id), 32'h121);

        // ---- branch during active stall, target 0x3FF (pc+1 wraps) ----
        fill_plain();
        do_reset(1'b0);
        run_to(5);
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd5;
        #1;
        check("bst_stall", 32'(PC_write), 32'd0);
        step();
        branch_taken  = 1'b1;
        branch_target = 10'h3FF;
        #1;
        check("bst_pc_write", 32'(PC_write), 32'd1);
        check("bst_bubble",   32'(bubble),   32'd1);
        check("bst_jump_sel", 32'(jump_sel), 32'd0);
        step();
        clear_inputs();
        check("bst_slot1", 32'(valid_id), 32'd0);
        step();
        check("bst_slot2", 32'(valid_id), 32'd0);
        step();
        check("bst_tgt_valid", 32'(valid_id),    32'd1);
        check("bst_tgt_instr", instr_id,         mem[10'h3FF]);
        check("bst_wrap_pc1",  32'(pc_plus1_id), 32'h000);

        // ---- asynchronous reset mid-stall ----
        fill_plain();
        do_reset(1'b0);
        run_to(5);
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd5;
        step();
        reset = 1'b1;
        #1;
        check("ars_valid",    32'(valid_id), 32'd0);
        check("ars_pc_write", 32'(PC_write), 32'd1);
        check("ars_bubble",   32'(bubble),   32'd1);
        check("ars_jump_sel", 32'(jump_sel), 32'd0);
        check("ars_instr",    instr_id,      32'd0);
        clear_inputs();
        @(negedge clock);
        reset = 1'b0;
        run_to(0);
        check("ars_first", instr_id, mem[0]);
        step();
        check("ars_second", instr_id, mem[1]);

        // ---- random traffic against the program-order model ----
        fill_random();
        do_reset(1'b0);
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            w = mem[m_pc];
            id_ex_mem_read = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       id_ex_rt = w[25:21];
                1:       id_ex_rt = w[20:16];
                2:       id_ex_rt = 5'd0;
                default: id_ex_rt = 5'($urandom);
            endcase
            branch_taken  = ($urandom_range(0, 11) == 0);
            branch_target = AW'($urandom);
            #1;
            hz = m_valid && id_ex_mem_read && (id_ex_rt != 5'd0) &&
                 ((id_ex_rt == w[25:21]) || (id_ex_rt == w[20:16]));
            st = hz && !branch_taken;
            js = m_valid && ((w[31:26] == OPC_J) || (w[31:26] == OPC_JAL)) && !st && !branch_taken;
            check("rnd_valid", 32'(valid_id), 32'(m_valid));
            if (m_valid) begin
                check("rnd_instr", instr_id, w);
                check("rnd_pc1", 32'(pc_plus1_id), 32'(m_pc + PC_ONE));
            end
            check("rnd_pc_write", 32'(PC_write), 32'(!st));
            check("rnd_bubble",   32'(bubble),   32'(!m_valid || hz || branch_taken));
            check("rnd_jump_sel", 32'(jump_sel), 32'(js));
            if (js) check("rnd_jaddr", 32'(jump_address), 32'(w[9:0]));
            model_edge(branch_taken, st, js, branch_target, w[AW-1:0]);
            step();
        end
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
